ram_dumper: RTL
===============

// Module: ram_dumper
// PURPOSE
//  Reads a RAM block sequentially from address 0 up to a programmed last address.
//  Emits each byte on a parallel byte interface with a one-cycle newData strobe.
//  Flow-controlled by a downstream transmitter (e.g. UART TX) via txReady.
//  Read-side counterpart of the byte-stream loader: dumps program/tape memory back out.
// PARAMETERS
//  addrSize  9  RAM address width; up to 2^addrSize bytes per dump
// PORTS
//  clk       in   1         single clock; all logic on posedge
//  reset     in   1         synchronous, active-low; 0 = reset
//  start     in   1         begin dump; sampled only in IDLE
//  lastAddr  in   addrSize  inclusive final address; captured on accepted start
//  read_rq   out  1         RAM read enable, high for exactly one cycle per byte
//  addrOut   out  addrSize  RAM read address
//  dataIn    in   8         RAM read data, valid 1 cycle after read_rq (registered read)
//  txReady   in   1         downstream can accept a byte
//  dataOut   out  8         byte to transmit; stable from strobe until next byte is latched
//  newData   out  1         one-cycle strobe: dataOut valid
//  busy      out  1         high from accepted start until done
//  done      out  1         one-cycle pulse after the final byte is strobed
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; read_rq, addrOut, dataOut, newData, busy,
//   done all 0; lastAddr register and checksum cleared. Mid-dump reset aborts with no
//   further strobes.
//  FSM: IDLE -> READ -> WAIT -> SEND -> GUARD -> (READ | FINISH) ; FINISH -> IDLE.
//   IDLE : start==1 => capture lastAddr, addrOut=0, busy=1, go READ.
//   READ : read_rq=1 for one cycle at addrOut; go WAIT.
//   WAIT : read_rq=0; latch dataIn into an internal byte register; go SEND.
//   SEND : wait for txReady==1; then dataOut=byte, newData=1 for one cycle; go GUARD.
//   GUARD: newData=0; txReady ignored this cycle. The downstream block must drop
//          txReady by the cycle after the strobe.
//          If addrOut==lastAddr, go FINISH. Else addrOut=addrOut+1, go READ.
//   FINISH: done=1 for one cycle, busy=0; go IDLE.
//  Latency: start at edge T -> read_rq at T+1 -> byte latched at T+2. First newData is
//   at T+3 if txReady is already high. Minimum 4 cycles per byte.
//  Address compare precedes increment, so lastAddr=2^addrSize-1 dumps every address and
//   never wraps. lastAddr=0 dumps exactly one byte.
//  start while busy: ignored. start held high through FINISH: a new dump begins on the
//   cycle after returning to IDLE.
//  txReady low indefinitely: stalls in SEND; read_rq stays 0; no timeout.
// CONFIGURATION
//  DUMPER_CHECKSUM_EN defined:
//   - An 8-bit running sum (mod 256) accumulates every byte strobed.
//   - After the last data byte, GUARD goes to SEND again with dataOut=sum, with no RAM read.
//   - Then GUARD -> FINISH.
//   - done follows the checksum strobe. Sum clears on accepted start.
//  Not defined: no sum logic; done follows the last data byte.
// TESTING
//  1 reset=0 for 2 cycles mid-dump -> all outputs 0, IDLE, no newData until next start.
//  2 RAM[0..3]=41,42,43,44, lastAddr=3, txReady=1 -> bytes 41,42,43,44.
//    Exactly 4 newData pulses, 4 cycles apart; first pulse at T+3; done one cycle after
//    the last pulse.
//  3 lastAddr=0, RAM[0]=7F -> single strobe with 7F.
//  4 lastAddr=511 (addrSize=9) -> 512 strobes; addrOut reaches 1FF with no wrap.
//    busy drops after the final byte.
//  5 txReady held low 20 cycles at byte 1 -> no strobe and read_rq=0 during the stall.
//    Byte 1 is strobed the cycle txReady rises. start pulses while busy are ignored.
//  6 DUMPER_CHECKSUM_EN, RAM[0..2]=FF,02,10 -> strobes FF,02,10 then 11; done after the 11 strobe.

Source files
------------

// File: rtl/ram_dumper.sv
`default_nettype none
// ============================================================================
// Module   : ram_dumper
// Summary  : Reads RAM from address 0 through lastAddr and sends each byte on a
//            flow-controlled byte interface. Define DUMPER_CHECKSUM_EN to append
//            a mod-256 sum of all data bytes.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dumper #(
    parameter int addrSize = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addrSize-1:0] lastAddr,
    output logic                read_rq,
    output logic [addrSize-1:0] addrOut,
    input  logic [7:0]          dataIn,
    input  logic                txReady,
    output logic [7:0]          dataOut,
    output logic                newData,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_SEND   = 3'd3,
        S_GUARD  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [addrSize-1:0] r_addr;
    logic [addrSize-1:0] r_last;
    logic [7:0]          r_byte;
    logic [7:0]          r_data_out;
    logic                w_strobe;
    logic                w_last;
    logic                w_accept;
`ifdef DUMPER_CHECKSUM_EN
    logic [7:0]          r_sum;
    logic                r_cks_phase;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_strobe = (r_state == S_SEND) && txReady;
    assign w_last   = (r_addr == r_last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_READ;
            S_READ:   w_state_nxt = S_WAIT;
            S_WAIT:   w_state_nxt = S_SEND;
            S_SEND:   if (txReady) w_state_nxt = S_GUARD;
            S_GUARD: begin
`ifdef DUMPER_CHECKSUM_EN
                if (r_cks_phase)   w_state_nxt = S_FINISH;
                else if (w_last)   w_state_nxt = S_SEND;
                else               w_state_nxt = S_READ;
`else
                if (w_last)        w_state_nxt = S_FINISH;
                else               w_state_nxt = S_READ;
`endif
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr     <= '0;
            r_last     <= '0;
            r_byte     <= 8'h00;
            r_data_out <= 8'h00;
`ifdef DUMPER_CHECKSUM_EN
            r_sum       <= 8'h00;
            r_cks_phase <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_last <= lastAddr;
                r_addr <= '0;
`ifdef DUMPER_CHECKSUM_EN
                r_sum       <= 8'h00;
                r_cks_phase <= 1'b0;
`endif
            end
            if (r_state == S_WAIT) begin
                r_byte <= dataIn;
            end
            if (w_strobe) begin
                r_data_out <= r_byte;
`ifdef DUMPER_CHECKSUM_EN
                if (!r_cks_phase) r_sum <= r_sum + r_byte;
`endif
            end
            // Compare before increment so the top address never wraps to 0
            if ((r_state == S_GUARD) && !w_last) begin
                r_addr <= r_addr + addrSize'(1);
            end
`ifdef DUMPER_CHECKSUM_EN
            if ((r_state == S_GUARD) && w_last && !r_cks_phase) begin
                r_cks_phase <= 1'b1;
                r_byte      <= r_sum;
            end
`endif
        end
    end

    assign read_rq = (r_state == S_READ);
    assign newData = (r_state == S_GUARD);
    assign done    = (r_state == S_FINISH);
    assign busy    = (r_state == S_READ) || (r_state == S_WAIT) ||
                     (r_state == S_SEND) || (r_state == S_GUARD);
    assign addrOut = r_addr;
    assign dataOut = r_data_out;

endmodule
`default_nettype wire
